// File: rtl/tri_bus_arbiter_if.sv
// Arbiter-side bundle: request vector in, one-hot grant plus owner/busy status out.
interface tri_bus_arbiter_if #(parameter int N = 4);
    localparam int OW = $clog2(N);

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [OW-1:0] owner;
    logic          busy;

    modport master (input req, output grant, output owner, output busy);
    modport slave  (output req, input grant, input owner, input busy);
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tri-state bus: registered one-hot grant, capped
// tenure and forced all-disabled turnaround between owners.
module tri_bus_arbiter #(
    parameter int N          = 4,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    tri_bus_arbiter_if.master bus
);
    localparam int OW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} state_t;

    state_t        state, state_n;
    logic [N-1:0]  grant, grant_n;
    logic [OW-1:0] owner, owner_n;
    logic [OW-1:0] last, last_n;
    logic [OW-1:0] win, idx;
    logic          found, load;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          busy;

    // Scan starts one past the last owner, so the previous owner is tried last.
    always_comb begin
        win   = last;
        idx   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = OW'((int'(last) + k) % N);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        owner_n = owner;
        last_n  = last;
        hold_n  = hold_cnt;
        tcnt_n  = tcnt;
        load    = 1'b0;
        case (state)
            IDLE: load = found;
            GRANT: begin
                if (bus.req[owner] && hold_cnt < HW'(MAX_HOLD)) begin
                    hold_n = hold_cnt + 1'b1;
                end else begin
                    state_n = TURN;
                    grant_n = '0;
                    tcnt_n  = TW'(1);
                end
            end
            TURN: begin
                if (tcnt < TW'(TURNAROUND)) tcnt_n = tcnt + 1'b1;
                else if (found)             load = 1'b1;
                else                        state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // New tenures only start from IDLE or a completed turnaround, never from GRANT.
        if (load) begin
            state_n      = GRANT;
            grant_n      = '0;
            grant_n[win] = 1'b1;
            owner_n      = win;
            last_n       = win;
            hold_n       = HW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            last     <= OW'(N - 1);
            hold_cnt <= '0;
            tcnt     <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            owner    <= owner_n;
            last     <= last_n;
            hold_cnt <= hold_n;
            tcnt     <= tcnt_n;
            busy     <= (state_n != IDLE);
        end
    end

    assign bus.grant = grant;
    assign bus.owner = owner;
    assign bus.busy  = busy;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter: three configurations share one request vector and
// are checked against tables, hand sequences and a tenure-level reference model.
module tb_tri_bus_arbiter;
    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    int         total = 0;
    int         bad   = 0;

    tri_bus_arbiter_if #(.N(4)) i0 ();
    tri_bus_arbiter_if #(.N(4)) i1 ();
    tri_bus_arbiter_if #(.N(4)) i2 ();
    assign i0.req = req;
    assign i1.req = req;
    assign i2.req = req;

    tri_bus_arbiter #(.N(4), .MAX_HOLD(4),  .TURNAROUND(1)) d0 (.clk(clk), .reset_n(reset_n), .bus(i0.master));
    tri_bus_arbiter #(.N(4), .MAX_HOLD(16), .TURNAROUND(1)) d1 (.clk(clk), .reset_n(reset_n), .bus(i1.master));
    tri_bus_arbiter #(.N(4), .MAX_HOLD(4),  .TURNAROUND(3)) d2 (.clk(clk), .reset_n(reset_n), .bus(i2.master));

    logic [3:0] g [3];
    logic [1:0] o [3];
    logic       b [3];
    assign g[0] = i0.grant; assign o[0] = i0.owner; assign b[0] = i0.busy;
    assign g[1] = i1.grant; assign o[1] = i1.owner; assign b[1] = i1.busy;
    assign g[2] = i2.grant; assign o[2] = i2.owner; assign b[2] = i2.busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, d, act, exp, $time);
        end
    endtask

    // Reference model: a tenure is "hold" granted cycles, followed by "gap" idle cycles.
    typedef struct {int hold; int gap; int own; int last;} mstate_t;
    mstate_t m [3];

    function automatic int mh_of(input int d); return (d == 1) ? 16 : 4; endfunction
    function automatic int ta_of(input int d); return (d == 2) ? 3 : 1;  endfunction

    function automatic mstate_t mstep(input mstate_t s, input logic [3:0] r, input int mh, input int ta);
        mstate_t n;
        bit      done;
        n    = s;
        done = 1'b0;
        if (s.hold > 0) begin
            if (r[2'(s.own)] && s.hold < mh) n.hold = s.hold + 1;
            else begin n.hold = 0; n.gap = ta; end
        end else if (s.gap > 1) begin
            n.gap = s.gap - 1;
        end else begin
            n.gap = 0;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (s.last + k) % 4;
                if (!done && r[2'(c)]) begin
                    done = 1'b1; n.own = c; n.last = c; n.hold = 1;
                end
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] mgrant(input mstate_t s);
        logic [3:0] r;
        r = '0;
        if (s.hold > 0) r[2'(s.own)] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) for (int d = 0; d < 3; d++) m[d] <= '{0, 0, 0, 3};
        else          for (int d = 0; d < 3; d++) m[d] <= mstep(m[d], req, mh_of(d), ta_of(d));
    end

    logic [3:0] prevg [3];
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (reset_n) begin
                chk("model_grant", d, 32'(g[d]), 32'(mgrant(m[d])));
                chk("model_owner", d, 32'(o[d]), 32'(m[d].own));
                chk("model_busy",  d, 32'(b[d]), 32'((m[d].hold > 0) || (m[d].gap > 0)));
                chk("at_most_one_driver", d, 32'($countones(g[d]) <= 1), 32'd1);
                if (prevg[d] != 4'b0 && g[d] != 4'b0) chk("no_direct_handoff", d, 32'(g[d]), 32'(prevg[d]));
            end
            prevg[d] <= reset_n ? g[d] : 4'b0;
        end
    end

    typedef struct {logic [3:0] req; logic [3:0] grant; logic [1:0] owner; logic busy;} vec_t;
    vec_t tab [$];

    function automatic void add(input logic [3:0] r, input logic [3:0] gr, input logic [1:0] ow, input logic bz);
        vec_t v;
        v.req = r; v.grant = gr; v.owner = ow; v.busy = bz;
        tab.push_back(v);
    endfunction

    task automatic run_tab(input int d, input string nm);
        for (int i = 0; i < tab.size(); i++) begin
            req = tab[i].req;
            @(posedge clk); #1;
            chk({nm, "_grant"}, d, 32'(g[d]), 32'(tab[i].grant));
            chk({nm, "_owner"}, d, 32'(o[d]), 32'(tab[i].owner));
            chk({nm, "_busy"},  d, 32'(b[d]), 32'(tab[i].busy));
        end
    endtask

    task automatic do_reset();
        req     = 4'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        int run;
        bit seen;
        reset_n = 1'b1;
        req     = 4'b0;
        #1;
        do_reset();

        // Reset and idle: all configurations quiet for 10 cycles.
        repeat (10) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                chk("idle_grant", d, 32'(g[d]), 32'd0);
                chk("idle_owner", d, 32'(o[d]), 32'd0);
                chk("idle_busy",  d, 32'(b[d]), 32'd0);
            end
        end

        // Single requester (MAX_HOLD=16).
        tab.delete();
        repeat (5) add(4'b0100, 4'b0100, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 2'd2, 1'b0);
        run_tab(1, "single");

        // Round robin, all requesting, MAX_HOLD=4 TURNAROUND=1.
        do_reset();
        tab.delete();
        for (int t = 0; t < 21; t++) begin
            int ten;
            ten = (t / 5) % 4;
            add(4'b1111, (t % 5 < 4) ? 4'(1 << ten) : 4'b0, 2'(ten), 1'b1);
        end
        run_tab(0, "rr");

        // Reset mid-tenure while requester 3 owns the bus.
        req  = 4'b1111;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk); #1;
            seen = (g[0] == 4'b1000);
        end
        chk("reach_owner3_timeout", 0, 32'(seen), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("async_reset_grant", d, 32'(g[d]), 32'd0);
            chk("async_reset_busy",  d, 32'(b[d]), 32'd0);
            chk("async_reset_owner", d, 32'(o[d]), 32'd0);
        end
        req = 4'b1001;
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_first_grant", 0, 32'(g[0]), 32'b0001);

        // Turnaround length 3.
        do_reset();
        tab.delete();
        repeat (2) add(4'b0011, 4'b0001, 2'd0, 1'b1);
        repeat (3) add(4'b0010, 4'b0000, 2'd0, 1'b1);
        add(4'b0010, 4'b0010, 2'd1, 1'b1);
        add(4'b0000, 4'b0000, 2'd1, 1'b1);
        run_tab(2, "turn3");

        // Tenure cap, MAX_HOLD=16.
        do_reset();
        req = 4'b0010;
        run = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            chk("cap_grant", 1, 32'(g[1]), (c % 17 < 16) ? 32'b0010 : 32'd0);
            run = (g[1] != 4'b0) ? run + 1 : 0;
            if (run > 16) chk("cap_run_len", 1, 32'(run), 32'd16);
        end

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        req = 4'b0;
        repeat (8) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("drain_idle", d, 32'(b[d]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
